// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and register-address/data types for the
//               register file and the decode / write-back stages.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 32 general-purpose register file with two combinational
//               read ports, one synchronous write port and hard-wired r0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] ND,
    input  logic [DATA_W-1:0] DI,
    input  logic              WREG,
    output logic [DATA_W-1:0] Q1,
    output logic [DATA_W-1:0] Q2
);

    localparam int          c_DEPTH = 2 ** ADDR_W;
    localparam [ADDR_W-1:0] c_ZERO  = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_regs [c_DEPTH];

    // r0 has no storage at all; it is a constant zero in the read array.
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < c_DEPTH; gi++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        logic              w_we;

        assign w_we = WREG && (ND == ADDR_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_we) begin
                r_q <= DI;
            end
        end

        assign w_regs[gi] = r_q;
    end

    // No write-through: reads always see the stored array contents.
    assign Q1 = (rs == c_ZERO) ? '0 : w_regs[rs];
    assign Q2 = (rt == c_ZERO) ? '0 : w_regs[rt];

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs, rt, ND;
    logic [31:0] DI;
    logic        WREG;
    logic [31:0] Q1, Q2;

    logic [31:0] mem [32];
    int          n_chk;
    int          n_bad;

    reg_file #(.DATA_W(32), .ADDR_W(5)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .rs   (rs),
        .rt   (rt),
        .ND   (ND),
        .DI   (DI),
        .WREG (WREG),
        .Q1   (Q1),
        .Q2   (Q2)
    );

    initial clk = 1'b1;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    // One rising edge; the model applies the write the spec allows, then
    // outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && WREG === 1'b1 && ND != 5'd0) mem[ND] = DI;
        #1;
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_q1"}, Q1, model_rd(rs));
        chk({tag, "_q2"}, Q2, model_rd(rt));
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b1; WREG = 1'b0; ND = '0; DI = '0; rs = 5'd1; rt = 5'd31;

        // Reset state
        #5;
        chk("rst_q1", Q1, 32'd0);
        chk("rst_q2", Q2, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // No bypass: old value visible before the edge, new one after
        rs = 5'd7; ND = 5'd7; DI = 32'h77; WREG = 1'b1;
        #1;
        chk("nobyp_before", Q1, 32'd0);
        tick();
        chk("nobyp_after", Q1, 32'h77);

        // r0 immutability
        rs = 5'd0; ND = 5'd0; DI = 32'hFFFF_FFFF; WREG = 1'b1;
        tick();
        chk("r0_write", Q1, 32'd0);

        // Write-enable gating, including X data while disabled
        ND = 5'd5; DI = 32'hA5A5_A5A5; WREG = 1'b1;
        tick();
        WREG = 1'b0; DI = 32'h1234_5678; rt = 5'd5;
        tick();
        chk("we_gate", Q2, 32'hA5A5_A5A5);
        DI = 'x; ND = 5'd5;
        tick();
        chk("we_gate_x", Q2, 32'hA5A5_A5A5);

        // Repeated write/readback: DI advances every half period
        rs = 5'd0; rt = 5'd1; ND = 5'd1; WREG = 1'b1;
        @(posedge clk);
        #5 DI = 32'd1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #5 DI = DI + 32'd1;
            tick();
            chk("rep_q2", Q2, 32'(2 * k));
            chk("rep_q1", Q1, 32'd0);
            #4 DI = DI + 32'd1;
        end

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            rs   = 5'($urandom_range(0, 31));
            rt   = 5'($urandom_range(0, 31));
            ND   = 5'($urandom_range(0, 31));
            DI   = $urandom;
            WREG = 1'($urandom_range(0, 1));
            #1;
            chk_both("rand_pre");
            tick();
            chk_both("rand_post");
        end

        // Asynchronous reset mid-run, and writes blocked during reset
        ND = 5'd1; DI = 32'h55; WREG = 1'b1; rs = 5'd1; rt = 5'd1;
        tick();
        chk("pre_rst_r1", Q1, 32'h55);
        #5 rst = 1'b1;
        #2;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        chk("arst_q1", Q1, 32'd0);
        chk("arst_q2", Q2, 32'd0);
        ND = 5'd3; DI = 32'hDEAD_BEEF; WREG = 1'b1; rs = 5'd3;
        tick();
        chk("rst_wr_blocked", Q1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", Q1, 32'd0);

        // Full sweep: r[i] = 3*i, then every (rs, rt) pair
        WREG = 1'b1;
        for (int i = 1; i < 32; i++) begin
            ND = 5'(i); DI = 32'(3 * i);
            tick();
        end
        WREG = 1'b0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                rs = 5'(a); rt = 5'(b);
                #1;
                chk("sweep_q1", Q1, 32'(3 * a));
                chk("sweep_q2", Q2, 32'(3 * b));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
